// File: rtl/common_types_pkg.sv
// ---------------------------------------------------------------------------
// common_types_pkg
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_t : halt state machine encoding (RUN / DRAIN / HALTED)
//   F2D..M2W       : pipeline latch indices used for en/flush vectors
//   reg_idx_t      : architectural register index (default 32 registers)
//   unit_id_t      : long-latency unit identifier (default 2 units)
//   unit_w()       : width of a unit id, never narrower than one bit
// ---------------------------------------------------------------------------
package common_types_pkg;

  localparam int DEF_NREGS  = 32;
  localparam int DEF_NUNITS = 2;

  // Pipeline latch indices.
  localparam int F2D = 0;
  localparam int D2E = 1;
  localparam int E2M = 2;
  localparam int M2W = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  typedef logic [$clog2(DEF_NREGS)-1:0]  reg_idx_t;
  typedef logic [$clog2(DEF_NUNITS)-1:0] unit_id_t;

  // A single-unit configuration still needs a one-bit id field.
  function automatic int unit_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Busy/owner table for registers written by long-latency units.
//   clk, rst_n     : clock, asynchronous active-low reset
//   set_en/rd/unit : mark a register busy and record which unit owns it
//   done, done_rd  : per-unit writeback; clears busy only if the unit owns it
//   rd_a/b/c       : three read ports (busy_a/b/c)
//   any_busy       : at least one register is outstanding
// Register 0 is never marked busy. A set and a clear to the same register in
// the same cycle resolve to busy (the new owner wins).
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int NREGS  = 32,
  parameter int NUNITS = 2,
  parameter int REG_W  = 5,
  parameter int UNIT_W = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_en,
  input  logic [REG_W-1:0]        set_rd,
  input  logic [UNIT_W-1:0]       set_unit,
  input  logic [NUNITS-1:0]       done,
  input  logic [NUNITS*REG_W-1:0] done_rd,
  input  logic [REG_W-1:0]        rd_a,
  input  logic [REG_W-1:0]        rd_b,
  input  logic [REG_W-1:0]        rd_c,
  output logic                    busy_a,
  output logic                    busy_b,
  output logic                    busy_c,
  output logic                    any_busy
);

  logic [NREGS-1:0]  busy;
  logic [UNIT_W-1:0] owner [NREGS];
  logic [NREGS-1:0]  set_vec;
  logic [NREGS-1:0]  clr_vec;

  // A writeback from a unit that no longer owns the register is stale
  // (the register was re-issued to another unit) and must be ignored.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int u = 0; u < NUNITS; u++) begin
        if (done[u] && (done_rd[u*REG_W +: REG_W] == REG_W'(r)) &&
            (owner[r] == UNIT_W'(u)))
          clr_vec[r] = 1'b1;
      end
      if (set_en && (set_rd == REG_W'(r)) && (r != 0))
        set_vec[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int r = 0; r < NREGS; r++) owner[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (set_vec[r]) begin
          busy[r]  <= 1'b1;
          owner[r] <= set_unit;
        end else if (clr_vec[r]) begin
          busy[r]  <= 1'b0;
        end
      end
    end
  end

  assign busy_a   = busy[rd_a];
  assign busy_b   = busy[rd_b];
  assign busy_c   = busy[rd_c];
  assign any_busy = |busy;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// ---------------------------------------------------------------------------
// scoreboard_hazard_unit
// Pipeline hazard controller with a registered scoreboard for long-latency
// units, deferred branch flush and a halt/drain state machine.
//   CLK, nRST            : clock, asynchronous active-low reset
//   ihit, dhit           : instruction / data cache hit
//   dread, dwrite        : MEM-stage data requests
//   branch               : MEM-stage redirect pulse
//   halt                 : halt instruction reached MEM
//   d2e_dread, d2e_rd    : load in EX and its destination
//   dec_rs1/rs2/rd       : operands of the decode instruction
//   issue_valid/unit     : decode instruction targets a long-latency unit
//   unit_busy            : unit cannot accept a new operation
//   done, done_rd        : per-unit writeback
//   en, flush            : per-latch enable and bubble-insert
//   halt_done            : pipeline drained and frozen
//   stall_cycles         : saturating count of cycles with en[0]=0
// ---------------------------------------------------------------------------
module scoreboard_hazard_unit
  import common_types_pkg::*;
#(
  parameter int NLATCH = 4,
  parameter int NUNITS = 2,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32,
  parameter int REG_W  = $clog2(NREGS),
  parameter int UNIT_W = unit_w(NUNITS)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    ihit,
  input  logic                    dhit,
  input  logic                    dread,
  input  logic                    dwrite,
  input  logic                    branch,
  input  logic                    halt,
  input  logic                    d2e_dread,
  input  logic [REG_W-1:0]        d2e_rd,
  input  logic [REG_W-1:0]        dec_rs1,
  input  logic [REG_W-1:0]        dec_rs2,
  input  logic [REG_W-1:0]        dec_rd,
  input  logic                    issue_valid,
  input  logic [UNIT_W-1:0]       issue_unit,
  input  logic [NUNITS-1:0]       unit_busy,
  input  logic [NUNITS-1:0]       done,
  input  logic [NUNITS*REG_W-1:0] done_rd,
  output logic [NLATCH-1:0]       en,
  output logic [NLATCH-1:0]       flush,
  output logic                    halt_done,
  output logic [CNT_W-1:0]        stall_cycles
);

  hazard_state_t state;
  logic          branch_pend;
  logic          branch_eff;
  logic          busy_rs1, busy_rs2, busy_rd, any_busy;
  logic          load_use;
  logic          sb_hazard;
  logic          issue_acc;
  logic          mem_req;

  assign branch_eff = branch | branch_pend;
  assign mem_req    = dread | dwrite;
  assign load_use   = d2e_dread && (d2e_rd != '0) &&
                      ((d2e_rd == dec_rs1) || (d2e_rd == dec_rs2));
  assign sb_hazard  = busy_rs1 | busy_rs2 | busy_rd |
                      (issue_valid & unit_busy[issue_unit]);
  assign issue_acc  = issue_valid & en[D2E] & ~flush[D2E];
  assign halt_done  = (state == HALTED);

  reg_scoreboard #(
    .NREGS  (NREGS),
    .NUNITS (NUNITS),
    .REG_W  (REG_W),
    .UNIT_W (UNIT_W)
  ) u_sb (
    .clk      (CLK),
    .rst_n    (nRST),
    .set_en   (issue_acc),
    .set_rd   (dec_rd),
    .set_unit (issue_unit),
    .done     (done),
    .done_rd  (done_rd),
    .rd_a     (dec_rs1),
    .rd_b     (dec_rs2),
    .rd_c     (dec_rd),
    .busy_a   (busy_rs1),
    .busy_b   (busy_rs2),
    .busy_c   (busy_rd),
    .any_busy (any_busy)
  );

  // Priority stall/flush decode; a taken redirect suppresses the decode-side
  // stalls because the decode instruction is about to be squashed anyway.
  always_comb begin
    en    = '1;
    flush = '0;
    if (state == HALTED) begin
      en = '0;
    end else if (mem_req && !dhit) begin
      en = '0;
    end else if (!mem_req && !ihit) begin
      en = '0;
    end else if (!ihit && !branch_eff) begin
      en[D2E:F2D]  = '0;
      flush[D2E]   = 1'b1;
    end else if (!branch_eff && load_use) begin
      en[D2E:F2D]  = '0;
      flush[D2E]   = 1'b1;
    end else if (!branch_eff && sb_hazard) begin
      en[D2E:F2D]  = '0;
      flush[D2E]   = 1'b1;
    end

    // While draining, hold fetch and keep bubbles flowing into EX.
    if (state == DRAIN) begin
      en[F2D]    = 1'b0;
      flush[D2E] = 1'b1;
    end

    if (branch_eff && ihit)
      flush[NLATCH-2:0] = '1;
  end

  // Control state: deferred branch, halt FSM, stall counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_pend  <= 1'b0;
      state        <= RUN;
      stall_cycles <= '0;
    end else begin
      if (branch_eff && ihit)
        branch_pend <= 1'b0;
      else if (branch && !ihit)
        branch_pend <= 1'b1;

      case (state)
        RUN:     if (halt) state <= DRAIN;
        DRAIN:   if (!any_busy && !mem_req) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase

      if (!en[F2D] && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: doc/scoreboard_hazard_unit.md
# scoreboard_hazard_unit

Parametrised pipeline hazard controller that replaces the purely combinational stall/flush logic with a registered scoreboard for long-latency functional units (multiplier, divider, …). It sits beside the pipeline latches. It drives per-latch enable and flush vectors, defers branch flushes that arrive during an instruction miss, and drains the pipeline through a halt state machine. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- NLATCH, 4: number of pipeline latches; index 0 = fetch→decode, index NLATCH-1 = last latch.
- NUNITS, 2: number of long-latency units tracked.
- NREGS, 32: architectural registers; REG_W = $clog2(NREGS).
- CNT_W, 32: stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit, dhit, dread, dwrite  in  1 each  cache handshakes; dread/dwrite are the MEM-stage requests.
- branch  in  1  MEM-stage redirect, one-cycle pulse.
- halt  in  1  halt instruction reached MEM.
- d2e_dread  in  1  load currently in EX.
- d2e_rd  in  REG_W  destination of the instruction in EX.
- dec_rs1, dec_rs2, dec_rd  in  REG_W  operands of the instruction in decode.
- issue_valid  in  1  decode instruction targets a long-latency unit.
- issue_unit  in  $clog2(NUNITS)  target unit.
- unit_busy  in  NUNITS  unit cannot accept a new operation.
- done  in  NUNITS  unit writes back this cycle.
- done_rd  in  NUNITS*REG_W  writeback register per unit.
- en  out  NLATCH  latch enables.
- flush  out  NLATCH  latch flushes (bubble insert).
- halt_done  out  1  pipeline drained and frozen.
- stall_cycles  out  CNT_W  cycles with en[0]=0, saturating.

## Operation
- Scoreboard: busy[NREGS] and owner[NREGS]. Register 0 is never busy.
- Issue is accepted when issue_valid & en[1] & ~flush[1]. On acceptance, busy[dec_rd] is set and owner = issue_unit, provided dec_rd≠0.
- done[u] clears busy[done_rd[u]] only if owner matches u. Otherwise the done is ignored. If a set and a clear hit the same register in the same cycle, the set wins.
- Outputs are combinational. Default: en all 1, flush all 0. The first matching priority applies:
  1. FSM in HALTED: en all 0.
  2. (dwrite|dread) & ~dhit: en all 0.
  3. ~dread & ~dwrite & ~ihit: en all 0.
  4. ~ihit & ~branch_eff: en[1:0]=0, flush[1]=1.
  5. Load-use, when ~branch_eff: d2e_dread & d2e_rd≠0 & d2e_rd∈{dec_rs1,dec_rs2} → en[1:0]=0, flush[1]=1.
  6. Scoreboard, when ~branch_eff: busy[dec_rs1]|busy[dec_rs2]|busy[dec_rd], or issue_valid & unit_busy[issue_unit] → en[1:0]=0, flush[1]=1.
- Deferred branch:
  - branch_eff = branch | branch_pend.
  - If branch_eff & ihit, flush[NLATCH-2:0]=1 (this applies on top of the priority result) and branch_pend clears.
  - If branch & ~ihit, branch_pend is set and held until an ihit cycle.
- Halt FSM:
  - RUN → DRAIN on halt.
  - DRAIN → HALTED when no register is busy and no dread/dwrite is pending.
  - HALTED is left only by reset.
  - In DRAIN, en[0]=0 and flush[1]=1, so no new issues enter; the rest follow the priority rules.
  - halt_done = (state==HALTED).
- stall_cycles increments every cycle en[0]=0 and holds at all-ones.

## Timing
- Reset (nRST low, asynchronous): busy and owner cleared, branch_pend=0, state=RUN, stall_cycles=0. After reset with idle inputs and ihit=1: en=all 1, flush=0, halt_done=0.
- Scoreboard effects take one cycle:
  - An issue accepted in cycle t stalls dependants from t+1.
  - A done in cycle t releases dependants in t+1; there is no same-cycle bypass.
- Load-use stall lasts exactly 1 cycle when hits are present.
- Branch flush is asserted in the same cycle as branch when ihit=1. Otherwise it is asserted in the first later cycle with ihit=1.
- HALTED is reached one cycle after the drain condition is met.

## Structure
- common_types_pkg holds: hazard_state_t (RUN, DRAIN, HALTED), latch index constants (F2D=0, D2E=1, E2M=2, M2W=3), and the REG_W/unit-id typedefs.
- Sub-module reg_scoreboard (busy/owner array, set/clear, three read ports) is natural. Everything else stays in the top module.

## Test plan
- Idle after reset, ihit=1 → en=4'b1111, flush=0, stall_cycles=0.
- Issue mul (unit 0) to x5; next instruction reads x5; done[0] with rd=5 three cycles later → en[1:0]=0 and flush[1]=1 for those three cycles, released the cycle after done. stall_cycles advances by 3.
- Load to x7 in EX and dec_rs2=7 → one cycle with en=4'b1100, flush=4'b0010.
- branch pulse with ihit=0, then ihit=1 two cycles later → flush=4'b0111 only in the ihit cycle; branch_pend returns to 0.
- Stale done: done[1] with rd=5 while owner[5]=0 → busy[5] stays set.
- halt with x9 busy → DRAIN until done clears x9, HALTED next cycle: en=0, halt_done=1. Assert nRST mid-DRAIN → immediate RUN and outputs back to the idle values.
